// File: rtl/fifo_level_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_level_unit_if
//  Description : Producer/consumer bundle for fifo_level_unit. The master
//                modport drives requests and data; the slave modport (the
//                FIFO) returns read data, occupancy, pointers and status.
//  Revision    : 1.0  initial release
// ============================================================================
interface fifo_level_unit_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
);
    logic                  wr;
    logic                  rd;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr, rd, w_data, clr_err,
        input  r_data, r_valid, full, empty, almost_full, almost_empty,
        input  count, wr_ptr, rd_ptr, overflow, underflow
    );

    modport slave (
        input  wr, rd, w_data, clr_err,
        output r_data, r_valid, full, empty, almost_full, almost_empty,
        output count, wr_ptr, rd_ptr, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/fifo_level_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_level_unit
//  Description : Synchronous FIFO with explicit occupancy count, programmable
//                almost-full / almost-empty thresholds and sticky overflow /
//                underflow flags. Build option FIFO_LEVEL_FWFT_EN selects
//                first-word fall-through reads; otherwise reads are
//                registered with one cycle of latency.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_level_unit #(
    parameter int ADDR_WIDTH      = 3,
    parameter int DATA_WIDTH      = 8,
    parameter int ALMOST_FULL_TH  = 6,
    parameter int ALMOST_EMPTY_TH = 1
) (
    input  wire                 clk,
    input  wire                 reset,
    fifo_level_unit_if.slave    bus
);
    localparam int                DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] C_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] C_AF_TH = ALMOST_FULL_TH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] C_AE_TH = ALMOST_EMPTY_TH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  full_w, empty_w;
    logic                  rd_ok_w, wr_ok_w;

    // Every status flag is a pure decode of the occupancy register.
    assign full_w  = (count_q == C_DEPTH);
    assign empty_w = (count_q == '0);

    // A write into a full FIFO is still taken when a read frees the slot.
    assign rd_ok_w = bus.rd & ~empty_w;
    assign wr_ok_w = bus.wr & (~full_w | rd_ok_w);

    // Next-state for pointers, occupancy and sticky errors (set beats clear).
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = (overflow_q  & ~bus.clr_err) | (bus.wr & ~wr_ok_w);
        underflow_d = (underflow_q & ~bus.clr_err) | (bus.rd & empty_w);
        if (wr_ok_w) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok_w) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_ok_w, rd_ok_w})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset wins over any request on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok_w) mem_q[wr_ptr_q] <= bus.w_data;
    end

`ifdef FIFO_LEVEL_FWFT_EN
    // Head word is presented combinationally; rd acknowledges it.
    assign bus.r_data  = mem_q[rd_ptr_q];
    assign bus.r_valid = ~empty_w;
`else
    logic [DATA_WIDTH-1:0] r_data_q;
    logic                  r_valid_q;

    // Registered read port: data loads on an accepted read and then holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_valid_q <= rd_ok_w;
            if (rd_ok_w) r_data_q <= mem_q[rd_ptr_q];
        end
    end

    assign bus.r_data  = r_data_q;
    assign bus.r_valid = r_valid_q;
`endif

    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_q >= C_AF_TH);
    assign bus.almost_empty = (count_q <= C_AE_TH);
    assign bus.count        = count_q;
    assign bus.wr_ptr       = wr_ptr_q;
    assign bus.rd_ptr       = rd_ptr_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule
`default_nettype wire
